// File: rtl/output_controller_burst.sv
// Frame buffer for the rasteriser that flushes a finished frame to SDRAM as Avalon-MM bursts.
// Define OC_PINGPONG_EN to get two banks, so the next frame can be written while the last one flushes.
module output_controller_burst #(
  parameter int unsigned       PIXEL_COUNT = 102400,
  parameter int unsigned       COLOR_W     = 8,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(28'h8000000),
  parameter int unsigned       BURST_LEN   = 16,
  parameter int unsigned       PIX_W       = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COLOR_W-1:0]         write_r,
  input  logic [COLOR_W-1:0]         write_g,
  input  logic [COLOR_W-1:0]         write_b,
  input  logic                       M9_write,
  input  logic                       read,
  input  logic [PIX_W-1:0]           pixel_number,
  output logic [COLOR_W-1:0]         read_r,
  output logic [COLOR_W-1:0]         read_g,
  output logic [COLOR_W-1:0]         read_b,
  input  logic                       frame_ready,
  output logic                       SD_write,
  output logic [ADDR_W-1:0]          SD_address,
  output logic [$clog2(BURST_LEN):0] SD_burstcount,
  output logic [DATA_W-1:0]          SD_wdata,
  input  logic                       waitrequest,
  output logic                       busy,
  output logic                       finished,
  output logic                       drop
);

  localparam int unsigned BC_W   = $clog2(BURST_LEN) + 1;
  localparam int unsigned PIXD_W = 3 * COLOR_W;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned CNT_W  = PIX_W + 1;
`ifdef OC_PINGPONG_EN
  localparam int unsigned BANKS       = 2;
  localparam bit          WR_IN_FLUSH = 1'b1;
`else
  localparam int unsigned BANKS       = 1;
  localparam bit          WR_IN_FLUSH = 1'b0;
`endif
  localparam int unsigned DEPTH = BANKS * PIXEL_COUNT;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_BURST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [BC_W-1:0]     left_q, left_d;
  logic                sd_write_d, busy_d, finished_d, drop_d;
  logic [ADDR_W-1:0]   sd_address_d;
  logic [BC_W-1:0]     sd_burstcount_d;
  logic [DATA_W-1:0]   sd_wdata_d;
  logic                wr_bank, fl_bank;
  logic [PIXD_W-1:0]   mem [DEPTH];

  logic                in_range_c, wr_ok_c, accept_c, last_pix_c;
  logic [CNT_W-1:0]    remaining_c;
  logic [BC_W-1:0]     burst_len_c;

  // Bank/pixel to flat buffer index; bank 1 lives above bank 0
  function automatic logic [IDX_W-1:0] idx(input logic bank, input logic [PIX_W-1:0] p);
    return IDX_W'(p) + (bank ? IDX_W'(PIXEL_COUNT) : IDX_W'(0));
  endfunction

`ifdef OC_PINGPONG_EN
  logic wr_bank_q;
  // Each accepted frame_ready hands the written bank to the flush and opens the other
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               wr_bank_q <= 1'b0;
    else if (frame_ready && state_q == S_IDLE) wr_bank_q <= ~wr_bank_q;
  end
  assign wr_bank = wr_bank_q;
  assign fl_bank = ~wr_bank_q;
`else
  assign wr_bank = 1'b0;
  assign fl_bank = 1'b0;
`endif

  assign in_range_c  = CNT_W'(pixel_number) < CNT_W'(PIXEL_COUNT);
  assign wr_ok_c     = M9_write && in_range_c && (WR_IN_FLUSH || !busy);
  assign accept_c    = SD_write && !waitrequest;
  assign last_pix_c  = CNT_W'(pix_q) == CNT_W'(PIXEL_COUNT - 1);
  assign remaining_c = CNT_W'(PIXEL_COUNT) - CNT_W'(pix_q);
  assign burst_len_c = (remaining_c >= CNT_W'(BURST_LEN)) ? BC_W'(BURST_LEN) : BC_W'(remaining_c);

  // Pixel storage: not reset, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[idx(wr_bank, pixel_number)] <= {write_b, write_g, write_r};
  end

  // Random-access read port; read-before-write on a same-index collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {read_b, read_g, read_r} <= '0;
    end else if (read) begin
      if (in_range_c) {read_b, read_g, read_r} <= mem[idx(wr_bank, pixel_number)];
      else            {read_b, read_g, read_r} <= '0;
    end
  end

  // Flush sequencer: next state and next output register values
  always_comb begin
    state_d         = state_q;
    pix_d           = pix_q;
    left_d          = left_q;
    sd_write_d      = SD_write;
    sd_address_d    = SD_address;
    sd_burstcount_d = SD_burstcount;
    sd_wdata_d      = SD_wdata;
    finished_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_ready) begin
          state_d = S_PREFETCH;
          pix_d   = '0;
        end
      end
      S_PREFETCH: begin
        sd_write_d      = 1'b1;
        sd_address_d    = BASE_ADDR + ADDR_W'(pix_q) * ADDR_W'(BYTES);
        sd_burstcount_d = burst_len_c;
        left_d          = burst_len_c;
        sd_wdata_d      = DATA_W'(mem[idx(fl_bank, pix_q)]);
        state_d         = S_BURST;
      end
      S_BURST: begin
        if (accept_c) begin
          if (last_pix_c) begin
            sd_write_d = 1'b0;
            finished_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            pix_d = PIX_W'(pix_q + PIX_W'(1));
            if (left_q == BC_W'(1)) begin
              sd_write_d = 1'b0;
              state_d    = S_PREFETCH;
            end else begin
              left_d     = BC_W'(left_q - BC_W'(1));
              sd_wdata_d = DATA_W'(mem[idx(fl_bank, PIX_W'(pix_q + PIX_W'(1)))]);
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    drop_d = (M9_write && !wr_ok_c) || (frame_ready && state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pix_q         <= '0;
      left_q        <= '0;
      SD_write      <= 1'b0;
      SD_address    <= BASE_ADDR;
      SD_burstcount <= '0;
      SD_wdata      <= '0;
      busy          <= 1'b0;
      finished      <= 1'b0;
      drop          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      left_q        <= left_d;
      SD_write      <= sd_write_d;
      SD_address    <= sd_address_d;
      SD_burstcount <= sd_burstcount_d;
      SD_wdata      <= sd_wdata_d;
      busy          <= busy_d;
      finished      <= finished_d;
      drop          <= drop_d;
    end
  end

endmodule

// File: tb/tb_output_controller_burst.sv
// Bench for output_controller_burst: table vectors, random fills and an SDRAM-side burst model.
`timescale 1ns/1ps
module tb_output_controller_burst;

  localparam int unsigned PC = 100;
  localparam int unsigned BL = 8;
  localparam int unsigned PW = 7;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 28;
  localparam logic [AW-1:0] BASE = 28'h8000000;
  localparam int NB = (PC + BL - 1) / BL;
`ifdef OC_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] write_r, write_g, write_b, read_r, read_g, read_b;
  logic          M9_write, read, frame_ready, waitrequest;
  logic [PW-1:0] pixel_number;
  logic          SD_write, busy, finished, drop;
  logic [AW-1:0] SD_address;
  logic [3:0]    SD_burstcount;
  logic [DW-1:0] SD_wdata;

  output_controller_burst #(
    .PIXEL_COUNT(PC), .COLOR_W(CW), .DATA_W(DW), .ADDR_W(AW),
    .BASE_ADDR(BASE), .BURST_LEN(BL), .PIX_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .write_r(write_r), .write_g(write_g), .write_b(write_b),
    .M9_write(M9_write), .read(read), .pixel_number(pixel_number),
    .read_r(read_r), .read_g(read_g), .read_b(read_b), .frame_ready(frame_ready),
    .SD_write(SD_write), .SD_address(SD_address), .SD_burstcount(SD_burstcount),
    .SD_wdata(SD_wdata), .waitrequest(waitrequest), .busy(busy),
    .finished(finished), .drop(drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: buffer banks, current write bank, frozen flush image
  logic [23:0] mdl [2][PC];
  int          wb = 0;
  bit          flushing = 0;
  logic [23:0] exp_img [PC];
  logic [7:0]  gs [PC];
  logic [7:0]  bs [PC];

  // SDRAM-side observation
  int            n_beats, n_bursts, burst_err, stab_err, fin_cnt, stall_seen;
  int            left, k;
  logic [AW-1:0] cur_addr, first_addr, last_addr;
  int            cur_cnt, first_cnt, last_cnt;
  logic [31:0]   sd_words [PC];
  bit            hold;
  logic [DW-1:0] h_data;
  logic [AW-1:0] h_addr;
  logic [3:0]    h_bc;

  always @(negedge clk) begin
    if (!reset) begin
      left = 0;
      hold = 0;
    end else begin
      if (hold && (!SD_write || SD_wdata !== h_data || SD_address !== h_addr || SD_burstcount !== h_bc))
        stab_err++;
      hold   = SD_write && waitrequest;
      h_data = SD_wdata;
      h_addr = SD_address;
      h_bc   = SD_burstcount;
      if (hold) stall_seen++;
      if (finished) fin_cnt++;
      if (SD_write && !waitrequest) begin
        if (left <= 0) begin
          int b, ecnt;
          b        = n_bursts;
          ecnt     = (PC - b * BL < BL) ? PC - b * BL : BL;
          cur_addr = SD_address;
          cur_cnt  = int'(SD_burstcount);
          if (cur_addr !== BASE + AW'(4 * BL * b) || cur_cnt != ecnt) burst_err++;
          if (n_bursts == 0) begin
            first_addr = cur_addr;
            first_cnt  = cur_cnt;
          end
          last_addr = cur_addr;
          last_cnt  = cur_cnt;
          left      = cur_cnt;
          k         = 0;
          n_bursts++;
        end else if (SD_address !== cur_addr || int'(SD_burstcount) != cur_cnt) begin
          burst_err++;
        end
        begin
          int widx;
          widx = int'((cur_addr - BASE) >> 2) + k;
          if (widx >= 0 && widx < PC) sd_words[widx] = SD_wdata;
          else burst_err++;
        end
        k++;
        left--;
        n_beats++;
      end
    end
  end

  // Slave model: random stalls, or a forced stall run once a chosen beat is reached
  bit wr_rand = 1'b1;
  int hold_at = -1;
  int hold_req = 0;
  initial begin
    waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_at >= 0 && n_beats >= hold_at && SD_write) begin
        hold_req = 5;
        hold_at  = -1;
      end
      if (hold_req > 0) begin
        waitrequest = 1'b1;
        hold_req--;
      end else if (wr_rand) begin
        waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
        waitrequest = 1'b0;
      end
    end
  end

  task automatic model_write(input int p, input logic [23:0] v);
    if (p < PC && (!flushing || PP)) mdl[wb][p] = v;
  endtask

  task automatic fill();
    for (int i = 0; i < PC; i++) begin
      M9_write     = 1'b1;
      pixel_number = PW'(i);
      write_r      = 8'(i);
      write_g      = gs[i];
      write_b      = bs[i];
      step();
      model_write(i, {bs[i], gs[i], 8'(i)});
    end
    M9_write = 1'b0;
  endtask

  task automatic start_flush();
    n_beats = 0; n_bursts = 0; burst_err = 0; stab_err = 0; fin_cnt = 0; stall_seen = 0;
    left = 0;
    for (int i = 0; i < PC; i++) sd_words[i] = 32'hDEADBEEF;
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("frame_ready_no_drop", drop, 1'b0);
    for (int i = 0; i < PC; i++) exp_img[i] = mdl[wb][i];
    if (PP) wb = wb ^ 1;
    flushing = 1'b1;
  endtask

  task automatic finish_flush(input string tag);
    int cyc, bad;
    cyc = 0;
    while (fin_cnt == 0 && cyc < 3000) begin
      step();
      cyc++;
    end
    chk({tag, "_finish_timeout"}, (fin_cnt == 0), 1'b0);
    step();
    step();
    flushing = 1'b0;
    chk({tag, "_finished_pulses"}, fin_cnt, 1);
    chk({tag, "_beats"}, n_beats, PC);
    chk({tag, "_bursts"}, n_bursts, NB);
    chk({tag, "_burst_errs"}, burst_err, 0);
    chk({tag, "_stall_unstable"}, stab_err, 0);
    chk({tag, "_last_addr"}, last_addr, BASE + AW'(4 * BL * (NB - 1)));
    chk({tag, "_last_cnt"}, last_cnt, PC - BL * (NB - 1));
    chk({tag, "_busy_after"}, busy, 1'b0);
    bad = 0;
    for (int i = 0; i < PC; i++) if (sd_words[i] !== {8'h00, exp_img[i]}) bad++;
    chk({tag, "_image_mismatches"}, bad, 0);
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [6:0] pix;
    logic [7:0] r, g, b;
    logic       exp_drop;
    logic       chk_rd;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vt [11];

  initial begin
    int bad, cyc;
    reset = 1'b0; M9_write = 1'b0; read = 1'b0; frame_ready = 1'b0;
    pixel_number = '0; write_r = '0; write_g = '0; write_b = '0;
    n_beats = 0; fin_cnt = 0;

    repeat (3) @(negedge clk);
    chk("rst_SD_write", SD_write, 1'b0);
    chk("rst_SD_address", SD_address, BASE);
    chk("rst_SD_burstcount", SD_burstcount, 4'd0);
    chk("rst_SD_wdata", SD_wdata, 32'd0);
    chk("rst_read_rgb", {read_b, read_g, read_r}, 24'd0);
    chk("rst_busy_fin_drop", {busy, finished, drop}, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Random image first, so every pixel has a known value
    for (int i = 0; i < PC; i++) begin
      gs[i] = 8'($urandom);
      bs[i] = 8'($urandom);
    end
    fill();

    vt[0]  = '{1'b1, 1'b0, 7'd0,   8'd1,  8'd2,  8'd3,  1'b0, 1'b0, 24'h0};
    vt[1]  = '{1'b1, 1'b0, 7'd1,   8'd200,8'd200,8'd201,1'b0, 1'b0, 24'h0};
    vt[2]  = '{1'b0, 1'b1, 7'd0,   8'd0,  8'd0,  8'd0,  1'b0, 1'b1, 24'h030201};
    vt[3]  = '{1'b0, 1'b1, 7'd1,   8'd0,  8'd0,  8'd0,  1'b0, 1'b1, 24'hC9C8C8};
    vt[4]  = '{1'b1, 1'b0, 7'd100, 8'd9,  8'd9,  8'd9,  1'b1, 1'b0, 24'h0};
    vt[5]  = '{1'b0, 1'b1, 7'd100, 8'd0,  8'd0,  8'd0,  1'b0, 1'b1, 24'h0};
    vt[6]  = '{1'b1, 1'b0, 7'd2,   8'd10, 8'd11, 8'd12, 1'b0, 1'b0, 24'h0};
    vt[7]  = '{1'b1, 1'b1, 7'd2,   8'd7,  8'd7,  8'd7,  1'b0, 1'b1, 24'h0C0B0A};
    vt[8]  = '{1'b0, 1'b1, 7'd2,   8'd0,  8'd0,  8'd0,  1'b0, 1'b1, 24'h070707};
    vt[9]  = '{1'b1, 1'b0, 7'd127, 8'd5,  8'd5,  8'd5,  1'b1, 1'b0, 24'h0};
    vt[10] = '{1'b0, 1'b1, 7'd0,   8'd0,  8'd0,  8'd0,  1'b0, 1'b1, 24'h030201};

    for (int i = 0; i < 11; i++) begin
      M9_write = vt[i].wr; read = vt[i].rd; pixel_number = vt[i].pix;
      write_r = vt[i].r; write_g = vt[i].g; write_b = vt[i].b;
      step();
      M9_write = 1'b0; read = 1'b0;
      if (vt[i].wr) model_write(int'(vt[i].pix), {vt[i].b, vt[i].g, vt[i].r});
      chk($sformatf("vec%0d_drop", i), drop, vt[i].exp_drop);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_read", i), {read_b, read_g, read_r}, vt[i].exp_rgb);
    end

    // Flush with random stalls; check the packed words of the first two pixels
    wr_rand = 1'b1;
    start_flush();
    finish_flush("s1");
    chk("s1_word0", sd_words[0], 32'h00030201);
    chk("s1_word1", sd_words[1], 32'h00C9C8C8);

    // r=i image, no stalls
    fill();
    wr_rand = 1'b0;
    start_flush();
    finish_flush("s2");
    bad = 0;
    for (int i = 0; i < PC; i++) if (sd_words[i][7:0] !== 8'(i)) bad++;
    chk("s2_byte_eq_index", bad, 0);

    // Same image, one 5-cycle stall inside the third burst
    fill();
    hold_at = 20;
    start_flush();
    finish_flush("s3");
    chk("s3_stall_cycles", stall_seen, 5);

    // Writes and frame_ready during the flush
    wr_rand = 1'b1;
    start_flush();
    repeat (5) step();
    M9_write = 1'b1; pixel_number = 7'd5; write_r = 8'd99; write_g = 8'd98; write_b = 8'd97;
    step();
    M9_write = 1'b0;
    model_write(5, {8'd97, 8'd98, 8'd99});
    chk("s4_busy_write_drop", drop, !PP);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("s4_busy_frame_drop", drop, 1'b1);
    finish_flush("s4");
    read = 1'b1; pixel_number = 7'd5;
    step();
    read = 1'b0;
    chk("s4_read_pix5", {read_b, read_g, read_r}, mdl[wb][5]);

    // Reset in the middle of a flush, then restart
    wr_rand = 1'b0;
    start_flush();
    cyc = 0;
    while (n_beats < 37 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("s5_reach_beat37_timeout", (n_beats < 37), 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("s5_async_SD_write", SD_write, 1'b0);
    chk("s5_async_busy", busy, 1'b0);
    chk("s5_async_addr_bc", {SD_address, SD_burstcount}, {BASE, 4'd0});
    flushing = 1'b0;
    wb = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    start_flush();
    cyc = 0;
    while (n_bursts == 0 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("s5_restart_addr", first_addr, BASE);
    chk("s5_restart_cnt", first_cnt, BL);
    finish_flush("s5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
